// File: rtl/ast_width_reducer_pkg.sv
// Shared types and slice arithmetic for the Avalon-ST width reducer.
// Everything here is parameter-free so the top can size it through arguments.
package ast_wr_package;

  typedef enum logic {
    ST_EMPTY,
    ST_SEND
  } wr_state_e;

  typedef enum logic [2:0] {
    TC_RESET,
    TC_FULL,
    TC_EMPTY20,
    TC_EMPTY31,
    TC_B2B,
    TC_STALL,
    TC_MIDRST
  } wr_test_e;

  localparam int WR_DEF_IN_W  = 256;
  localparam int WR_DEF_OUT_W = 64;

  function automatic int wr_ratio(input int in_w, input int out_w);
    return in_w / out_w;
  endfunction

  function automatic int wr_bytes(input int w);
    return w / 8;
  endfunction

  // Number of narrow slices that carry at least one valid byte of a wide beat.
  function automatic int wr_slices(input logic eop, input int empty,
                                   input int in_bytes, input int out_bytes);
    int v;
    if (!eop) return in_bytes / out_bytes;
    v = in_bytes - empty;
    return (v + out_bytes - 1) / out_bytes;
  endfunction

  // Unused high bytes left over in the final slice of an eop beat.
  function automatic int wr_empty_out(input logic eop, input int empty,
                                      input int in_bytes, input int out_bytes);
    int v;
    if (!eop) return 0;
    v = in_bytes - empty;
    return wr_slices(eop, empty, in_bytes, out_bytes) * out_bytes - v;
  endfunction

endpackage

// File: rtl/ast_width_reducer.sv
// Avalon-ST width reducer: holds one wide beat and streams its valid narrow
// slices LSB-first, one per cycle, preserving sop/eop/channel/empty.
module ast_width_reducer
  import ast_wr_package::*;
#(
  parameter int DATA_IN_W   = WR_DEF_IN_W,
  parameter int EMPTY_IN_W  = (DATA_IN_W / 8 > 1) ? $clog2(DATA_IN_W / 8) : 1,
  parameter int CHANNEL_W   = 10,
  parameter int DATA_OUT_W  = WR_DEF_OUT_W,
  parameter int EMPTY_OUT_W = (DATA_OUT_W / 8 > 1) ? $clog2(DATA_OUT_W / 8) : 1
) (
  input  logic                   clk_i,
  input  logic                   srst_n_i,
  input  logic [DATA_IN_W-1:0]   ast_data_i,
  input  logic                   ast_startofpacket_i,
  input  logic                   ast_endofpacket_i,
  input  logic                   ast_valid_i,
  input  logic [EMPTY_IN_W-1:0]  ast_empty_i,
  input  logic [CHANNEL_W-1:0]   ast_channel_i,
  output logic                   ast_ready_o,
  output logic [DATA_OUT_W-1:0]  ast_data_o,
  output logic                   ast_startofpacket_o,
  output logic                   ast_endofpacket_o,
  output logic                   ast_valid_o,
  output logic [EMPTY_OUT_W-1:0] ast_empty_o,
  output logic [CHANNEL_W-1:0]   ast_channel_o,
  input  logic                   ast_ready_i
);

  localparam int R         = wr_ratio(DATA_IN_W, DATA_OUT_W);
  localparam int IN_BYTES  = wr_bytes(DATA_IN_W);
  localparam int OUT_BYTES = wr_bytes(DATA_OUT_W);
  localparam int IDX_W     = (R > 1) ? $clog2(R) : 1;

  wr_state_e                     state_q;
  logic [DATA_IN_W-1:0]          data_q;
  logic                          sop_q, eop_q;
  logic [EMPTY_OUT_W-1:0]        empty_q, empty_d;
  logic [CHANNEL_W-1:0]          chan_q;
  logic [IDX_W-1:0]              idx_q, last_idx_q, last_idx_d;
  logic [R-1:0][DATA_OUT_W-1:0]  slc;
  logic                          is_last, out_hs, in_acc;

  // Slice count and tail empty are resolved at capture so the send path
  // only compares the index against a stored last index.
  assign last_idx_d = IDX_W'(wr_slices(ast_endofpacket_i, int'(ast_empty_i),
                                       IN_BYTES, OUT_BYTES) - 1);
  assign empty_d    = EMPTY_OUT_W'(wr_empty_out(ast_endofpacket_i, int'(ast_empty_i),
                                                IN_BYTES, OUT_BYTES));

  assign is_last     = (idx_q == last_idx_q);
  assign ast_valid_o = (state_q == ST_SEND);
  assign out_hs      = ast_valid_o & ast_ready_i;
  assign ast_ready_o = (state_q == ST_EMPTY) | (out_hs & is_last);
  assign in_acc      = ast_valid_i & ast_ready_o;

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state_q    <= ST_EMPTY;
      data_q     <= '0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      empty_q    <= '0;
      chan_q     <= '0;
      idx_q      <= '0;
      last_idx_q <= '0;
    end else if (in_acc) begin
      state_q    <= ST_SEND;
      data_q     <= ast_data_i;
      sop_q      <= ast_startofpacket_i;
      eop_q      <= ast_endofpacket_i;
      empty_q    <= empty_d;
      chan_q     <= ast_channel_i;
      idx_q      <= '0;
      last_idx_q <= last_idx_d;
    end else if (out_hs) begin
      if (is_last) state_q <= ST_EMPTY;
      else         idx_q   <= idx_q + IDX_W'(1);
    end
  end

  assign slc                 = data_q;
  assign ast_data_o          = slc[idx_q];
  assign ast_channel_o       = chan_q;
  assign ast_startofpacket_o = ast_valid_o & sop_q & (idx_q == '0);
  assign ast_endofpacket_o   = ast_valid_o & eop_q & is_last;
  assign ast_empty_o         = ast_endofpacket_o ? empty_q : '0;

endmodule

// File: tb/tb_ast_width_reducer.sv
// Scoreboard bench for ast_width_reducer: the driver chops each accepted beat
// into expected byte chunks, the monitor pops and checks every output handshake.
module tb_ast_width_reducer;
  import ast_wr_package::*;

  logic         clk = 1'b0;
  logic         srst_n_i;
  logic [255:0] ast_data_i;
  logic         ast_startofpacket_i, ast_endofpacket_i, ast_valid_i;
  logic [4:0]   ast_empty_i;
  logic [9:0]   ast_channel_i;
  logic         ast_ready_o;
  logic [63:0]  ast_data_o;
  logic         ast_startofpacket_o, ast_endofpacket_o, ast_valid_o;
  logic [2:0]   ast_empty_o;
  logic [9:0]   ast_channel_o;
  logic         ast_ready_i;

  ast_width_reducer dut (
    .clk_i(clk), .srst_n_i(srst_n_i),
    .ast_data_i(ast_data_i), .ast_startofpacket_i(ast_startofpacket_i),
    .ast_endofpacket_i(ast_endofpacket_i), .ast_valid_i(ast_valid_i),
    .ast_empty_i(ast_empty_i), .ast_channel_i(ast_channel_i),
    .ast_ready_o(ast_ready_o), .ast_data_o(ast_data_o),
    .ast_startofpacket_o(ast_startofpacket_o), .ast_endofpacket_o(ast_endofpacket_o),
    .ast_valid_o(ast_valid_o), .ast_empty_o(ast_empty_o),
    .ast_channel_o(ast_channel_o), .ast_ready_i(ast_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    int          nb;
    bit          sop, eop;
    int          emp;
    int          ch;
  } exp_t;

  exp_t     sb[$];
  int       vec = 0, miss = 0;
  bit       rnd_rdy = 1'b0;
  bit       trk = 1'b0, seen = 1'b0;
  int       bubbles = 0;
  wr_test_e tc = TC_RESET;

  function automatic logic pick();
    return rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s [%s]: got %h want %h", nm, tc.name(), act, exp);
    end
  endtask

  // Reference: valid bytes of the beat cut into 8-byte chunks in order.
  task automatic push_exp(input logic [255:0] d, input bit sop, input bit eop,
                          input int emp, input int ch);
    int   v;
    exp_t e;
    v = eop ? 32 - emp : 32;
    for (int c = 0; c * 8 < v; c++) begin
      e.nb  = (v - c * 8 >= 8) ? 8 : v - c * 8;
      e.d   = d[c*64 +: 64];
      e.sop = sop && (c == 0);
      e.eop = eop && ((c + 1) * 8 >= v);
      e.emp = e.eop ? 8 - e.nb : 0;
      e.ch  = ch;
      sb.push_back(e);
    end
  endtask

  task automatic send_beat(input logic [255:0] d, input bit sop, input bit eop,
                           input int emp, input int ch);
    int g = 0;
    @(negedge clk);
    ast_data_i = d; ast_startofpacket_i = sop; ast_endofpacket_i = eop;
    ast_empty_i = 5'(emp); ast_channel_i = 10'(ch); ast_valid_i = 1'b1;
    ast_ready_i = pick();
    #1;
    while (!ast_ready_o && g < 1000) begin
      @(negedge clk); ast_ready_i = pick(); #1; g++;
    end
    if (!ast_ready_o) chk("accept_timeout", 64'(ast_ready_o), 64'd1);
    else push_exp(d, sop, eop, emp, ch);
  endtask

  task automatic idle1();
    @(negedge clk);
    ast_valid_i = 1'b0;
    ast_ready_i = pick();
    #1;
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() > 0 && g < 1000) begin idle1(); g++; end
    chk("drain_left", 64'(sb.size()), 64'd0);
    idle1();
    chk("idle_valid", 64'(ast_valid_o), 64'd0);
  endtask

  function automatic logic [255:0] rnd_beat();
    logic [255:0] d;
    for (int b = 0; b < 8; b++) d[b*32 +: 32] = $urandom;
    return d;
  endfunction

  // Monitor: samples after the driver has settled ready_i for the coming edge.
  always @(negedge clk) begin
    logic [63:0] m;
    exp_t e;
    #2;
    if (srst_n_i && ast_valid_o && ast_ready_i) begin
      if (sb.size() == 0) begin
        chk("unexpected_slice", ast_data_o, 64'hx);
      end else begin
        e = sb.pop_front();
        m = '0;
        for (int b = 0; b < e.nb; b++) m[b*8 +: 8] = 8'hFF;
        chk("slice_data", ast_data_o & m, e.d & m);
        chk("slice_sop",  64'(ast_startofpacket_o), 64'(e.sop));
        chk("slice_eop",  64'(ast_endofpacket_o), 64'(e.eop));
        chk("slice_empty", 64'(ast_empty_o), 64'(e.emp));
        chk("slice_chan", 64'(ast_channel_o), 64'(e.ch));
      end
    end
    if (trk) begin
      if (ast_valid_o) seen = 1'b1;
      else if (seen && sb.size() != 0) bubbles++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [255:0] d;
    int nb, ch, emp;
    srst_n_i = 1'b0; ast_valid_i = 1'b0; ast_ready_i = 1'b0;
    ast_data_i = '0; ast_startofpacket_i = 1'b0; ast_endofpacket_i = 1'b0;
    ast_empty_i = '0; ast_channel_i = '0;
    repeat (3) @(negedge clk);
    #1;
    tc = TC_RESET;
    chk("rst_valid", 64'(ast_valid_o), 64'd0);
    chk("rst_data", ast_data_o, 64'd0);
    chk("rst_sop_eop", {62'd0, ast_startofpacket_o, ast_endofpacket_o}, 64'd0);
    chk("rst_empty_chan", {51'd0, ast_empty_o, ast_channel_o}, 64'd0);
    srst_n_i = 1'b1;
    idle1();
    chk("rst_ready", 64'(ast_ready_o), 64'd1);

    // Full beat: 4 slices, first is bytes 0..7
    tc = TC_FULL;
    for (int b = 0; b < 32; b++) d[b*8 +: 8] = 8'(b);
    send_beat(d, 1, 1, 0, 3);
    idle1();
    chk("full_first", ast_data_o, 64'h0706050403020100);
    chk("full_first_sop", 64'(ast_startofpacket_o), 64'd1);
    drain();

    // empty 20 -> 12 valid bytes -> 2 slices, empty_o 4
    tc = TC_EMPTY20;
    send_beat(d, 1, 1, 20, 7);
    idle1();
    chk("e20_ready_s0", 64'(ast_ready_o), 64'd0);
    idle1();
    chk("e20_ready_s1", 64'(ast_ready_o), 64'd1);
    chk("e20_empty", 64'(ast_empty_o), 64'd4);
    drain();

    // empty 31 -> single slice with sop+eop, empty_o 7
    tc = TC_EMPTY31;
    send_beat(d, 1, 1, 31, 1);
    idle1();
    chk("e31_sop_eop", {62'd0, ast_startofpacket_o, ast_endofpacket_o}, 64'd3);
    chk("e31_empty", 64'(ast_empty_o), 64'd7);
    drain();

    // Back-to-back packets, no bubbles
    tc = TC_B2B;
    bubbles = 0; seen = 1'b0; trk = 1'b1;
    for (int i = 0; i < 3; i++) send_beat(rnd_beat(), i == 0, i == 2, 0, 5);
    for (int i = 0; i < 2; i++) send_beat(rnd_beat(), i == 0, i == 1, 0, 9);
    drain();
    trk = 1'b0;
    chk("b2b_bubbles", 64'(bubbles), 64'd0);

    // Random packets with 50% downstream stalls and input gaps
    tc = TC_STALL;
    rnd_rdy = 1'b1;
    for (int p = 0; p < 30; p++) begin
      nb = $urandom_range(1, 4);
      ch = $urandom_range(0, 1023);
      for (int i = 0; i < nb; i++) begin
        emp = $urandom_range(0, 31);
        send_beat(rnd_beat(), i == 0, i == nb - 1, emp, ch);
        if ($urandom_range(0, 3) == 0) idle1();
      end
    end
    drain();
    rnd_rdy = 1'b0;

    // Reset while the second slice of a beat is on the output
    tc = TC_MIDRST;
    send_beat(rnd_beat(), 1, 0, 0, 2);
    idle1();
    @(negedge clk);
    srst_n_i = 1'b0; ast_valid_i = 1'b0; sb.delete();
    @(negedge clk);
    #1;
    chk("midrst_valid", 64'(ast_valid_o), 64'd0);
    chk("midrst_eop", 64'(ast_endofpacket_o), 64'd0);
    chk("midrst_data", ast_data_o, 64'd0);
    srst_n_i = 1'b1;
    idle1();
    chk("midrst_ready", 64'(ast_ready_o), 64'd1);
    send_beat(rnd_beat(), 1, 0, 0, 4);
    send_beat(rnd_beat(), 0, 1, 13, 4);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
